merge_2to1_stream: RTL and testbench
====================================

// Module: merge_2to1_stream
// PURPOSE
//  Streaming 2-to-1 merge element for the merge-sort lower layers. Two input streams (A, B)
//  each carry back-to-back sorted runs of RUN_LEN keys; block emits one merged sorted run of
//  2*RUN_LEN keys per input run pair. Buffered inputs, registered output, valid/ready on all ports.
//  Replaces the fixed 3-register compare/swap datapath in cascaded merge trees.
// PARAMETERS
//  DATA_WIDTH  8  key width; unsigned comparison
//  RUN_LEN     4  keys per input run (>=1); output run = 2*RUN_LEN
//  FIFO_DEPTH  4  per-input buffer depth, power of 2, >=2
//  DESCENDING  0  0: ascending merge; 1: descending merge
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           async active-low reset
//  clear      in   1           sync flush: FIFOs, counters, FSM, output reg
//  a_data     in   DATA_WIDTH  stream A key
//  a_valid    in   1           stream A valid
//  a_ready    out  1           stream A ready (= !fifo_a_full)
//  b_data     in   DATA_WIDTH  stream B key
//  b_valid    in   1           stream B valid
//  b_ready    out  1           stream B ready (= !fifo_b_full)
//  out_data   out  DATA_WIDTH  merged key (registered)
//  out_valid  out  1           out_data valid
//  out_ready  in   1           downstream ready
//  out_last   out  1           marks final key of each 2*RUN_LEN output run
//  busy       out  1           FSM not IDLE
// BEHAVIOUR
//  Reset: rst_n async, active-low; clock clk. Reset -> out_valid=0, out_data=0, out_last=0,
//   busy=0, a_ready=b_ready=1, FIFOs empty, cnt_a=cnt_b=0, state IDLE. Same result from clear (sync);
//   clear wins over every simultaneous push/pop/load.
//  Input: push when x_valid&&x_ready; no pass-through when full (ready depends on full only).
//   Push and pop in the same cycle on a non-full FIFO are both honoured.
//  Output reg loads when (!out_valid || out_ready) and a head is selected; data held stable
//   while out_valid && !out_ready. Min latency: key accepted cycle N -> out_valid at N+2.
//  Counters cnt_a, cnt_b: $clog2(RUN_LEN+1) bits; keys popped from A/B in the current run.
//  FSM:
//   IDLE    -> MERGE when either FIFO non-empty.
//   MERGE   needs both heads; pick A if A<=B (asc) / A>=B (desc), else B. Ties pick A (stable).
//           cnt_a reaches RUN_LEN -> DRAIN_B; cnt_b reaches RUN_LEN -> DRAIN_A.
//   DRAIN_A pop A only until cnt_a==RUN_LEN.  DRAIN_B pop B only until cnt_b==RUN_LEN.
//   Pop of the 2*RUN_LEN-th key: out_last=1 on that key, cnt_a=cnt_b=0, -> IDLE if both FIFOs
//   empty after pop else MERGE (back-to-back runs, no bubble).
//  Keys of the next run already buffered are never popped before current run completes.
//  One input starved: no output in MERGE (waits); other FIFO fills, its ready drops at FIFO_DEPTH.
//  RUN_LEN=1: MERGE emits the smaller key, then DRAIN of the other, then last.
//  Input run ordering is not checked; unsorted runs give unsorted output, no error flag.
// STRUCTURE
//  Package merge_pkg: typedef key_t (logic [DATA_WIDTH-1:0] via param class/macro),
//   enum merge_state_e {IDLE, MERGE, DRAIN_A, DRAIN_B}, function key_before(a,b,desc).
//  Sub-module: merge_fifo (sync FIFO, async reset, flush, full/empty, show-ahead head);
//   instantiated twice. Top holds FSM, counters, compare, output register.
// TESTING
//  1 Asc, RUN_LEN=4: A=1,4,6,9 B=2,3,7,8, out_ready=1 -> 1,2,3,4,6,7,8,9; out_last only on 9.
//  2 Drain: A=1,2,3,4 B=5,6,7,8 -> DRAIN_B after 4th pop; output 1..8, busy 0 afterwards.
//  3 Desc (DESCENDING=1): A=9,6,4,1 B=8,7,3,2 -> 9,8,7,6,4,3,2,1, out_last on 1.
//  4 Backpressure: out_ready pattern 1,0,1,0.. on test 1 -> same sequence, no loss/dup,
//    out_data stable while stalled; b_valid=0, 5 keys offered on A -> a_ready=0 after 4 accepted.
//  5 Back-to-back: two run pairs streamed without gaps -> 16 keys, out_last on 8th and 16th,
//    no idle cycle between runs; ties A=5,5,5,5 B=5,5,5,5 -> A keys all popped first.
//  6 clear after 3rd output, then rst_n pulse mid-run -> outputs/ready/busy at reset values
//    next cycle (clear) / immediately (rst_n); fresh run pair then merges correctly.

Source files
------------

// File: rtl/merge_pkg.sv
// Shared types and helpers for the streaming merge-sort elements.
package merge_pkg;

  // Keys are compared zero-extended to this width, so any DATA_WIDTH up to it is supported.
  localparam int KEY_MAX_WIDTH = 32;

  typedef logic [KEY_MAX_WIDTH-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MERGE   = 2'd1,
    DRAIN_A = 2'd2,
    DRAIN_B = 2'd3
  } merge_state_e;

  // True when key a must leave before key b. Ties favour a, which keeps the merge stable.
  function automatic logic key_before(input key_t a, input key_t b, input logic desc);
    return desc ? (a >= b) : (a <= b);
  endfunction

endpackage

// File: rtl/merge_fifo.sv
// Synchronous show-ahead FIFO used as the per-input buffer of the merge element.
// The head is visible whenever the FIFO is not empty, so a pop can be decided combinationally.
module merge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign count_o = wrPtr_q - rdPtr_q;
  assign head_o  = mem_q[rdPtr_q[AW-1:0]];

  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  // Next pointer values; push and pop in the same cycle both advance.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
    if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
  end

  // Pointer registers; flush empties the buffer and overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: a slot is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (doPush && !flush_i) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/merge_2to1_stream.sv
// Streaming 2-to-1 merge element: two inputs each carry back-to-back sorted runs of RUN_LEN
// keys, the output carries one sorted run of 2*RUN_LEN keys per input run pair.
module merge_2to1_stream
  import merge_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RUN_LEN    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter bit DESCENDING = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int CW  = $clog2(RUN_LEN + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  RUN_CNT  = CW'(RUN_LEN);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [FCW-1:0] FIFO_ONE = FCW'(1);

  merge_state_e          state_q, state_d, effState;
  logic [CW-1:0]         cntA_q, cntA_d;
  logic [CW-1:0]         cntB_q, cntB_d;

  logic [DATA_WIDTH-1:0] headA, headB;
  logic                  fullA, fullB;
  logic                  emptyA, emptyB;
  logic [FCW-1:0]        countA, countB;
  logic                  pushA, pushB;
  logic                  popA, popB;
  logic                  lastPop;
  logic                  canLoad;
  logic                  aEmptyAfter, bEmptyAfter;
  logic [DATA_WIDTH-1:0] loadKey;

  logic [DATA_WIDTH-1:0] outData_q;
  logic                  outValid_q;
  logic                  outLast_q;

  assign pushA   = a_valid && !fullA;
  assign pushB   = b_valid && !fullB;
  assign a_ready = !fullA;
  assign b_ready = !fullB;

  // The output register may take a new key when it is empty or being drained this cycle.
  assign canLoad = !outValid_q || out_ready;

  merge_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifoA (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (clear),
    .push_i  (a_valid),
    .data_i  (a_data),
    .pop_i   (popA),
    .head_o  (headA),
    .full_o  (fullA),
    .empty_o (emptyA),
    .count_o (countA)
  );

  merge_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifoB (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (clear),
    .push_i  (b_valid),
    .data_i  (b_data),
    .pop_i   (popB),
    .head_o  (headB),
    .full_o  (fullB),
    .empty_o (emptyB),
    .count_o (countB)
  );

  // Head selection, pop decisions, run counting and next state. IDLE with buffered data
  // behaves as MERGE in the same cycle so a freshly arrived pair needs no extra bubble.
  always_comb begin
    effState = state_q;
    if ((state_q == IDLE) && (!emptyA || !emptyB)) effState = MERGE;

    state_d     = effState;
    cntA_d      = cntA_q;
    cntB_d      = cntB_q;
    popA        = 1'b0;
    popB        = 1'b0;
    lastPop     = 1'b0;
    loadKey     = headA;
    aEmptyAfter = 1'b0;
    bEmptyAfter = 1'b0;

    case (effState)
      MERGE: begin
        if (canLoad && !emptyA && !emptyB) begin
          if (key_before(key_t'(headA), key_t'(headB), DESCENDING)) begin
            popA   = 1'b1;
            cntA_d = cntA_q + CNT_ONE;
            if (cntA_d == RUN_CNT) state_d = DRAIN_B;
          end else begin
            popB    = 1'b1;
            loadKey = headB;
            cntB_d  = cntB_q + CNT_ONE;
            if (cntB_d == RUN_CNT) state_d = DRAIN_A;
          end
        end
      end
      DRAIN_A: begin
        if (canLoad && !emptyA) begin
          popA   = 1'b1;
          cntA_d = cntA_q + CNT_ONE;
          if (cntA_d == RUN_CNT) lastPop = 1'b1;
        end
      end
      DRAIN_B: begin
        if (canLoad && !emptyB) begin
          popB    = 1'b1;
          loadKey = headB;
          cntB_d  = cntB_q + CNT_ONE;
          if (cntB_d == RUN_CNT) lastPop = 1'b1;
        end
      end
      default: ;
    endcase

    aEmptyAfter = !pushA && (emptyA || (popA && (countA == FIFO_ONE)));
    bEmptyAfter = !pushB && (emptyB || (popB && (countB == FIFO_ONE)));

    if (lastPop) begin
      cntA_d  = '0;
      cntB_d  = '0;
      state_d = (aEmptyAfter && bEmptyAfter) ? IDLE : MERGE;
    end
  end

  // FSM state and per-run pop counters; clear behaves like reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cntA_q  <= '0;
      cntB_q  <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      cntA_q  <= '0;
      cntB_q  <= '0;
    end else begin
      state_q <= state_d;
      cntA_q  <= cntA_d;
      cntB_q  <= cntB_d;
    end
  end

  // Output register: loads on every pop, holds while stalled, empties once accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
    end else if (clear) begin
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
    end else if (popA || popB) begin
      outData_q  <= loadKey;
      outValid_q <= 1'b1;
      outLast_q  <= lastPop;
    end else if (out_ready) begin
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
    end
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign out_last  = outLast_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_merge_2to1_stream.sv
// Bench for merge_2to1_stream: an ascending and a descending instance share the stimulus;
// expected output runs come from a stable sort of each input run pair.
module tb_merge_2to1_stream;

  localparam int DW      = 8;
  localparam int RL      = 4;
  localparam int FD      = 4;
  localparam int TIMEOUT = 2000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          useDesc;
  logic [DW-1:0] aData, bData;
  logic          aValid, bValid;
  logic          outReady;

  logic          ascAReady, ascBReady, ascOutValid, ascOutLast, ascBusy;
  logic [DW-1:0] ascOutData;
  logic          dscAReady, dscBReady, dscOutValid, dscOutLast, dscBusy;
  logic [DW-1:0] dscOutData;

  logic          obsAReady, obsBReady, obsOutValid, obsOutLast, obsBusy;
  logic [DW-1:0] obsOutData;

  int            checks = 0;
  int            errors = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [DW-1:0] scratch[$];
  logic [DW-1:0] expData[$];
  logic          expLast[$];

  always #5 clk = ~clk;

  merge_2to1_stream #(.DATA_WIDTH(DW), .RUN_LEN(RL), .FIFO_DEPTH(FD), .DESCENDING(1'b0)) dutAsc (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .a_data(aData), .a_valid(aValid && !useDesc), .a_ready(ascAReady),
    .b_data(bData), .b_valid(bValid && !useDesc), .b_ready(ascBReady),
    .out_data(ascOutData), .out_valid(ascOutValid), .out_ready(outReady),
    .out_last(ascOutLast), .busy(ascBusy)
  );

  merge_2to1_stream #(.DATA_WIDTH(DW), .RUN_LEN(RL), .FIFO_DEPTH(FD), .DESCENDING(1'b1)) dutDesc (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .a_data(aData), .a_valid(aValid && useDesc), .a_ready(dscAReady),
    .b_data(bData), .b_valid(bValid && useDesc), .b_ready(dscBReady),
    .out_data(dscOutData), .out_valid(dscOutValid), .out_ready(outReady),
    .out_last(dscOutLast), .busy(dscBusy)
  );

  assign obsAReady   = useDesc ? dscAReady   : ascAReady;
  assign obsBReady   = useDesc ? dscBReady   : ascBReady;
  assign obsOutValid = useDesc ? dscOutValid : ascOutValid;
  assign obsOutLast  = useDesc ? dscOutLast  : ascOutLast;
  assign obsOutData  = useDesc ? dscOutData  : ascOutData;
  assign obsBusy     = useDesc ? dscBusy     : ascBusy;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Strict ordering: equal keys never overtake, so sorting A-then-B keeps A first on ties.
  function automatic logic precedes(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic desc);
    return desc ? (x > y) : (x < y);
  endfunction

  task automatic stableSortScratch(input logic desc);
    logic [DW-1:0] key;
    int j;
    for (int i = 1; i < scratch.size(); i++) begin
      key = scratch[i];
      j = i - 1;
      while (j >= 0 && precedes(key, scratch[j], desc)) begin
        scratch[j+1] = scratch[j];
        j--;
      end
      scratch[j+1] = key;
    end
  endtask

  task automatic pushRandomRun(input bit isB, input logic desc);
    int span;
    span = ($urandom_range(0, 1) == 1) ? 15 : 255;
    scratch.delete();
    for (int i = 0; i < RL; i++) scratch.push_back(DW'($urandom_range(0, span)));
    stableSortScratch(desc);
    for (int i = 0; i < RL; i++) begin
      if (isB) qb.push_back(scratch[i]);
      else     qa.push_back(scratch[i]);
    end
  endtask

  task automatic buildExpected(input int pairs, input logic desc);
    expData.delete();
    expLast.delete();
    for (int p = 0; p < pairs; p++) begin
      scratch.delete();
      for (int i = 0; i < RL; i++) scratch.push_back(qa[p*RL+i]);
      for (int i = 0; i < RL; i++) scratch.push_back(qb[p*RL+i]);
      stableSortScratch(desc);
      for (int i = 0; i < 2*RL; i++) begin
        expData.push_back(scratch[i]);
        expLast.push_back(i == 2*RL-1);
      end
    end
  endtask

  task automatic applyStimulus(input bit isB, input bit gaps);
    int n;
    int waitCycles;
    string tag;
    n = isB ? qb.size() : qa.size();
    tag = isB ? "b_ready wait" : "a_ready wait";
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          if (isB) bValid = 1'b0; else aValid = 1'b0;
        end
      end
      @(negedge clk);
      if (isB) begin bValid = 1'b1; bData = qb[i]; end
      else     begin aValid = 1'b1; aData = qa[i]; end
      waitCycles = 0;
      while (!(isB ? obsBReady : obsAReady) && waitCycles < TIMEOUT) begin
        @(negedge clk);
        waitCycles++;
      end
      if (waitCycles >= TIMEOUT) begin
        checkOutput(tag, 0, 1);
        break;
      end
    end
    @(negedge clk);
    if (isB) bValid = 1'b0; else aValid = 1'b0;
  endtask

  // readyMode 0: always ready, 1: alternate 1,0,1,0, 2: random.
  task automatic collectOutputs(input int readyMode, input bit gapless, input int expFirst);
    int got = 0;
    int cyc = 0;
    int firstValid = -1;
    int lastXfer = 0;
    logic stalled = 1'b0;
    logic [DW-1:0] held = '0;
    while (got < expData.size() && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        checkOutput("stall out_valid", obsOutValid, 1);
        checkOutput("stall out_data", obsOutData, held);
      end
      case (readyMode)
        0:       outReady = 1'b1;
        1:       outReady = cyc[0];
        default: outReady = 1'($urandom_range(0, 1));
      endcase
      if (obsOutValid && firstValid < 0) firstValid = cyc;
      if (obsOutValid && outReady) begin
        checkOutput($sformatf("out_data[%0d]", got), obsOutData, expData[got]);
        checkOutput($sformatf("out_last[%0d]", got), obsOutLast, expLast[got]);
        got++;
        lastXfer = cyc;
      end
      stalled = obsOutValid && !outReady;
      held = obsOutData;
    end
    checkOutput("output count", got, expData.size());
    if (gapless)      checkOutput("gapless span", lastXfer - firstValid + 1, expData.size());
    if (expFirst > 0) checkOutput("first out latency", firstValid, expFirst);
    outReady = 1'b1;
  endtask

  task automatic runPairs(input int pairs, input logic desc, input int readyMode,
                          input bit gaps, input bit gapless, input int expFirst);
    useDesc = desc;
    buildExpected(pairs, desc);
    @(posedge clk);
    fork
      applyStimulus(1'b0, gaps);
      applyStimulus(1'b1, gaps);
      collectOutputs(readyMode, gapless, expFirst);
    join
    repeat (2) @(negedge clk);
    checkOutput("busy after run", obsBusy, 0);
    checkOutput("out_valid after run", obsOutValid, 0);
    qa.delete();
    qb.delete();
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int accepted;
    rst_n = 1'b0; clear = 1'b0; useDesc = 1'b0;
    aValid = 1'b0; bValid = 1'b0; aData = '0; bData = '0; outReady = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset out_valid", obsOutValid, 0);
    checkOutput("reset out_data", obsOutData, 0);
    checkOutput("reset out_last", obsOutLast, 0);
    checkOutput("reset busy", obsBusy, 0);
    checkOutput("reset a_ready", obsAReady, 1);
    checkOutput("reset b_ready", obsBReady, 1);
    checkOutput("reset desc busy", dscBusy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] ascending interleaved run");
    qa = '{8'd1, 8'd4, 8'd6, 8'd9}; qb = '{8'd2, 8'd3, 8'd7, 8'd8};
    runPairs(1, 1'b0, 0, 1'b0, 1'b1, 3);

    $display("[TB] drain run");
    qa = '{8'd1, 8'd2, 8'd3, 8'd4}; qb = '{8'd5, 8'd6, 8'd7, 8'd8};
    runPairs(1, 1'b0, 0, 1'b0, 1'b1, 0);

    $display("[TB] descending run");
    qa = '{8'd9, 8'd6, 8'd4, 8'd1}; qb = '{8'd8, 8'd7, 8'd3, 8'd2};
    runPairs(1, 1'b1, 0, 1'b0, 1'b1, 0);

    $display("[TB] alternating backpressure");
    qa = '{8'd1, 8'd4, 8'd6, 8'd9}; qb = '{8'd2, 8'd3, 8'd7, 8'd8};
    runPairs(1, 1'b0, 1, 1'b0, 1'b0, 0);

    $display("[TB] starved B, A fills");
    useDesc = 1'b0;
    accepted = 0;
    @(negedge clk);
    aValid = 1'b1; aData = 8'd42;
    for (int i = 0; i < 6; i++) begin
      if (obsAReady) accepted++;
      @(negedge clk);
    end
    aValid = 1'b0;
    checkOutput("starved accepted", accepted, FD);
    checkOutput("starved a_ready", obsAReady, 0);
    checkOutput("starved out_valid", obsOutValid, 0);
    checkOutput("starved busy", obsBusy, 1);
    pulseClear();
    checkOutput("clear a_ready", obsAReady, 1);
    checkOutput("clear busy", obsBusy, 0);

    $display("[TB] back-to-back run pairs");
    for (int p = 0; p < 2; p++) begin
      pushRandomRun(1'b0, 1'b0);
      pushRandomRun(1'b1, 1'b0);
    end
    runPairs(2, 1'b0, 0, 1'b0, 1'b1, 0);

    $display("[TB] tie run");
    useDesc = 1'b0;
    outReady = 1'b0;
    qa = '{8'd5, 8'd5, 8'd5, 8'd5}; qb = '{8'd5, 8'd5, 8'd5, 8'd5};
    fork
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
    join
    checkOutput("tie out_valid", obsOutValid, 1);
    checkOutput("tie a_ready", obsAReady, 1);
    checkOutput("tie b_ready", obsBReady, 0);
    buildExpected(1, 1'b0);
    collectOutputs(0, 1'b0, 0);
    qa.delete(); qb.delete();
    repeat (2) @(negedge clk);
    checkOutput("tie busy after", obsBusy, 0);

    $display("[TB] clear mid-run then reset mid-run");
    outReady = 1'b0;
    qa = '{8'd1, 8'd4, 8'd6, 8'd9}; qb = '{8'd2, 8'd3, 8'd7, 8'd8};
    fork
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
    join
    outReady = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      checkOutput($sformatf("pre-clear out_data[%0d]", i), obsOutData, i);
      @(negedge clk);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clear out_valid", obsOutValid, 0);
    checkOutput("clear out_data", obsOutData, 0);
    checkOutput("clear out_last", obsOutLast, 0);
    checkOutput("clear busy", obsBusy, 0);
    checkOutput("clear a_ready", obsAReady, 1);
    checkOutput("clear b_ready", obsBReady, 1);
    outReady = 1'b0;
    qa = '{8'd10, 8'd20}; qb = '{8'd15};
    fork
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
    join
    @(negedge clk);
    checkOutput("pre-reset busy", obsBusy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", obsOutValid, 0);
    checkOutput("async reset out_data", obsOutData, 0);
    checkOutput("async reset busy", obsBusy, 0);
    checkOutput("async reset a_ready", obsAReady, 1);
    checkOutput("async reset b_ready", obsBReady, 1);
    @(negedge clk);
    rst_n = 1'b1;
    outReady = 1'b1;
    qa.delete(); qb.delete();
    pushRandomRun(1'b0, 1'b0);
    pushRandomRun(1'b1, 1'b0);
    runPairs(1, 1'b0, 0, 1'b0, 1'b1, 0);

    $display("[TB] random runs");
    for (int it = 0; it < 8; it++) begin
      logic desc;
      int pairs;
      desc  = 1'($urandom_range(0, 1));
      pairs = $urandom_range(1, 3);
      for (int p = 0; p < pairs; p++) begin
        pushRandomRun(1'b0, desc);
        pushRandomRun(1'b1, desc);
      end
      runPairs(pairs, desc, 2, 1'b1, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
